// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the character-LCD refresh sequencer.
// Included by the frame controller and the bus-write timing engine.
package lcd_pkg;

   localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
   localparam logic [7:0] DISP_ON       = 8'h0C;
   localparam logic [7:0] CLEAR         = 8'h01;
   localparam logic [7:0] HOME          = 8'h02;
   localparam logic [7:0] ENTRY_INC     = 8'h06;
   localparam logic [7:0] DDRAM_L1      = 8'h80;
   localparam logic [7:0] DDRAM_L2      = 8'hC0;

   localparam int unsigned INIT_LEN   = 32'd6;
   localparam int unsigned INIT_PTR_W = 32'd3;

   typedef enum logic [2:0] {
      ST_PWRUP = 3'd0,
      ST_INIT  = 3'd1,
      ST_ADDR  = 3'd2,
      ST_CHAR  = 3'd3,
      ST_IDLE  = 3'd4
   } frame_state_t;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_SETUP = 2'd1,
      WR_EHIGH = 2'd2,
      WR_HOLD  = 2'd3
   } wr_state_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [7:0] init_cmd(input logic [INIT_PTR_W-1:0] ptr);
      logic [7:0] cmd;
      case (ptr)
         3'd0, 3'd1, 3'd2: cmd = FUNC_SET_8B2L;
         3'd3:             cmd = DISP_ON;
         3'd4:             cmd = CLEAR;
         3'd5:             cmd = ENTRY_INC;
         default:          cmd = FUNC_SET_8B2L;
      endcase
      return cmd;
   endfunction

   // Clear and return-home need the long execution wait; everything else is short.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return (rs == 1'b0) && ((data == CLEAR) || (data == HOME));
   endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One LCD bus write per start: SETUP, then lcd_e high, then the post-write execution wait.
// A new start accepted on the done cycle chains writes back to back with no idle gap.
module lcd_bus_writer
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC    = 32'd4,
   parameter int unsigned E_HIGH_CYC   = 32'd12,
   parameter int unsigned CMD_WAIT_CYC = 32'd2000,
   parameter int unsigned CLR_WAIT_CYC = 32'd82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data,
   output logic       done,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic [7:0] lcd_data
);

   localparam int unsigned MAX_CYC = max_u(max_u(SETUP_CYC, E_HIGH_CYC),
                                           max_u(CMD_WAIT_CYC, CLR_WAIT_CYC));
   localparam int unsigned CNT_W = $clog2(MAX_CYC + 32'd1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 32'd1);
   localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(E_HIGH_CYC - 32'd1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 32'd1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 32'd1);

   wr_state_t        state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s, hold_last_s;
   logic             long_r, done_s, start_ok_s, setup_end_s;
   logic             lcd_rs_r, lcd_e_r;
   logic [7:0]       lcd_data_r;

   // Phase sequencing and cycle counting for the write in flight.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      done_s      = 1'b0;
      setup_end_s = 1'b0;
      hold_last_s = long_r ? CLR_LAST : CMD_LAST;
      case (state_r)
         WR_IDLE: begin
            if (start) begin
               state_nxt_s = WR_SETUP;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_nxt_s   = {CNT_W{1'b0}};
            end
         end
         WR_SETUP: begin
            if (cnt_r == SETUP_LAST) begin
               setup_end_s = 1'b1;
               state_nxt_s = WR_EHIGH;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         WR_EHIGH: begin
            if (cnt_r == EHIGH_LAST) begin
               state_nxt_s = WR_HOLD;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         WR_HOLD: begin
            if (cnt_r == hold_last_s) begin
               done_s      = 1'b1;
               state_nxt_s = start ? WR_SETUP : WR_IDLE;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = WR_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
         end
      endcase
      start_ok_s = start && ((state_r == WR_IDLE) || done_s);
   end

   // Phase/counter state and the registered LCD pins; rs is taken at start, data at end of setup.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= WR_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         long_r     <= 1'b0;
         lcd_rs_r   <= 1'b0;
         lcd_e_r    <= 1'b0;
         lcd_data_r <= 8'h00;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         lcd_e_r <= (state_nxt_s == WR_EHIGH);
         if (start_ok_s) begin
            lcd_rs_r <= rs;
         end
         if (setup_end_s) begin
            lcd_data_r <= data;
            long_r     <= is_long_cmd(lcd_rs_r, data);
         end
      end
   end

   assign done     = done_s;
   assign lcd_rs   = lcd_rs_r;
   assign lcd_e    = lcd_e_r;
   assign lcd_data = lcd_data_r;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Frame sequencer for a 16x2 character LCD: power-up delay, init list, then periodic 32-char
// scans of the display list, each line preceded by its DDRAM address command.
module lcd_refresh_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned PWRUP_CYC    = 32'd750000,
   parameter int unsigned E_HIGH_CYC   = 32'd12,
   parameter int unsigned SETUP_CYC    = 32'd4,
   parameter int unsigned CMD_WAIT_CYC = 32'd2000,
   parameter int unsigned CLR_WAIT_CYC = 32'd82000,
   parameter int unsigned REFRESH_CYC  = 32'd5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       refresh_req,
   input  logic [7:0] char_in,
   output logic [4:0] index,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data,
   output logic       init_done,
   output logic       frame_busy
);

   localparam int unsigned TMR_W = $clog2(max_u(PWRUP_CYC, REFRESH_CYC) + 32'd1);
   localparam logic [TMR_W-1:0]      PWRUP_LAST   = TMR_W'(PWRUP_CYC - 32'd1);
   localparam logic [TMR_W-1:0]      REFRESH_LAST = TMR_W'(REFRESH_CYC - 32'd1);
   localparam logic [INIT_PTR_W-1:0] INIT_LAST    = INIT_PTR_W'(INIT_LEN - 32'd1);

   frame_state_t            state_r, state_nxt_s;
   logic [TMR_W-1:0]        tmr_r, tmr_nxt_s;
   logic [INIT_PTR_W-1:0]   init_ptr_r, init_ptr_nxt_s;
   logic [4:0]              index_r, index_nxt_s;
   logic                    init_done_r, init_done_nxt_s;
   logic                    frame_busy_r, frame_busy_nxt_s;
   logic                    pend_r, pend_nxt_s;
   logic                    start_s, start_rs_s, wr_done_s;
   logic [7:0]              wr_data_s;

   // Frame FSM: decides when the next write launches and what it carries.
   always_comb begin
      state_nxt_s      = state_r;
      tmr_nxt_s        = tmr_r;
      init_ptr_nxt_s   = init_ptr_r;
      index_nxt_s      = index_r;
      init_done_nxt_s  = init_done_r;
      frame_busy_nxt_s = frame_busy_r;
      pend_nxt_s       = pend_r | refresh_req;
      start_s          = 1'b0;
      start_rs_s       = 1'b0;
      case (state_r)
         ST_PWRUP: begin
            if (tmr_r == PWRUP_LAST) begin
               state_nxt_s    = ST_INIT;
               tmr_nxt_s      = {TMR_W{1'b0}};
               init_ptr_nxt_s = {INIT_PTR_W{1'b0}};
               start_s        = 1'b1;
            end else begin
               tmr_nxt_s      = tmr_r + {{(TMR_W-1){1'b0}}, 1'b1};
            end
         end
         ST_INIT: begin
            if (wr_done_s && (init_ptr_r == INIT_LAST)) begin
               state_nxt_s      = ST_ADDR;
               init_done_nxt_s  = 1'b1;
               index_nxt_s      = 5'd0;
               frame_busy_nxt_s = 1'b1;
               start_s          = 1'b1;
            end else if (wr_done_s) begin
               init_ptr_nxt_s   = init_ptr_r + {{(INIT_PTR_W-1){1'b0}}, 1'b1};
               start_s          = 1'b1;
            end else begin
               start_s          = 1'b0;
            end
         end
         ST_ADDR: begin
            if (wr_done_s) begin
               state_nxt_s = ST_CHAR;
               start_s     = 1'b1;
               start_rs_s  = 1'b1;
            end else begin
               start_s     = 1'b0;
            end
         end
         ST_CHAR: begin
            if (wr_done_s && (index_r == 5'd15)) begin
               state_nxt_s      = ST_ADDR;
               index_nxt_s      = 5'd16;
               start_s          = 1'b1;
            end else if (wr_done_s && (index_r == 5'd31)) begin
               state_nxt_s      = ST_IDLE;
               index_nxt_s      = 5'd0;
               frame_busy_nxt_s = 1'b0;
               tmr_nxt_s        = {TMR_W{1'b0}};
            end else if (wr_done_s) begin
               index_nxt_s      = index_r + 5'd1;
               start_s          = 1'b1;
               start_rs_s       = 1'b1;
            end else begin
               start_s          = 1'b0;
            end
         end
         ST_IDLE: begin
            if (pend_r || refresh_req || (tmr_r == REFRESH_LAST)) begin
               state_nxt_s      = ST_ADDR;
               frame_busy_nxt_s = 1'b1;
               pend_nxt_s       = 1'b0;
               tmr_nxt_s        = {TMR_W{1'b0}};
               start_s          = 1'b1;
            end else begin
               tmr_nxt_s        = tmr_r + {{(TMR_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = ST_PWRUP;
            tmr_nxt_s   = {TMR_W{1'b0}};
         end
      endcase
   end

   // Byte presented to the writer for the write currently in its setup phase.
   always_comb begin
      case (state_r)
         ST_INIT: wr_data_s = init_cmd(init_ptr_r);
         ST_ADDR: wr_data_s = index_r[4] ? DDRAM_L2 : DDRAM_L1;
         ST_CHAR: wr_data_s = char_in;
         default: wr_data_s = 8'h00;
      endcase
   end

   // Frame FSM, timer, pointers and status flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_PWRUP;
         tmr_r        <= {TMR_W{1'b0}};
         init_ptr_r   <= {INIT_PTR_W{1'b0}};
         index_r      <= 5'd0;
         init_done_r  <= 1'b0;
         frame_busy_r <= 1'b0;
         pend_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         tmr_r        <= tmr_nxt_s;
         init_ptr_r   <= init_ptr_nxt_s;
         index_r      <= index_nxt_s;
         init_done_r  <= init_done_nxt_s;
         frame_busy_r <= frame_busy_nxt_s;
         pend_r       <= pend_nxt_s;
      end
   end

   lcd_bus_writer #(
      .SETUP_CYC    (SETUP_CYC),
      .E_HIGH_CYC   (E_HIGH_CYC),
      .CMD_WAIT_CYC (CMD_WAIT_CYC),
      .CLR_WAIT_CYC (CLR_WAIT_CYC)
   ) u_writer (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s),
      .rs       (start_rs_s),
      .data     (wr_data_s),
      .done     (wr_done_s),
      .lcd_rs   (lcd_rs),
      .lcd_e    (lcd_e),
      .lcd_data (lcd_data)
   );

   assign lcd_rw     = 1'b0;
   assign index      = index_r;
   assign init_done  = init_done_r;
   assign frame_busy = frame_busy_r;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Scoreboard bench for lcd_refresh_ctrl with reduced timing parameters and a registered
// display-list model (char = 0x2D + index).
module tb_lcd_refresh_ctrl;

   logic       clk, rst, refresh_req;
   logic [7:0] char_in;
   logic [4:0] index;
   logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_busy;
   logic [7:0] lcd_data;

   int n_pass   = 0;
   int n_checks = 0;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
      logic [4:0] idx;
      logic       fb;
      logic       idn;
      logic [7:0] lo;
   } exp_t;

   exp_t exp_q[$];

   lcd_refresh_ctrl #(
      .PWRUP_CYC    (32'd20),
      .E_HIGH_CYC   (32'd3),
      .SETUP_CYC    (32'd2),
      .CMD_WAIT_CYC (32'd5),
      .CLR_WAIT_CYC (32'd10),
      .REFRESH_CYC  (32'd50)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .refresh_req (refresh_req),
      .char_in     (char_in),
      .index       (index),
      .lcd_rs      (lcd_rs),
      .lcd_rw      (lcd_rw),
      .lcd_e       (lcd_e),
      .lcd_data    (lcd_data),
      .init_done   (init_done),
      .frame_busy  (frame_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Display-list ROM model with one cycle of registered latency.
   always @(posedge clk) begin
      char_in <= 8'h2D + {3'b000, index};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic rs, input logic [7:0] data, input logic [4:0] idx,
                       input logic fb, input logic idn, input logic [7:0] lo);
      exp_t e;
      e.rs = rs; e.data = data; e.idx = idx; e.fb = fb; e.idn = idn; e.lo = lo;
      exp_q.push_back(e);
   endtask

   // Low cycles before a write's lcd_e rise: preceding wait + setup (22 = power-up 20 + setup 2).
   task automatic push_init();
      push(1'b0, 8'h38, 5'd0, 1'b0, 1'b0, 8'd22);
      push(1'b0, 8'h38, 5'd0, 1'b0, 1'b0, 8'd7);
      push(1'b0, 8'h38, 5'd0, 1'b0, 1'b0, 8'd7);
      push(1'b0, 8'h0C, 5'd0, 1'b0, 1'b0, 8'd7);
      push(1'b0, 8'h01, 5'd0, 1'b0, 1'b0, 8'd7);
      push(1'b0, 8'h06, 5'd0, 1'b0, 1'b0, 8'd12);
   endtask

   task automatic push_frame(input logic [7:0] first_lo);
      push(1'b0, 8'h80, 5'd0, 1'b1, 1'b1, first_lo);
      for (int i = 0; i < 32; i++) begin
         if (i == 16) begin
            push(1'b0, 8'hC0, 5'd16, 1'b1, 1'b1, 8'd7);
         end
         push(1'b1, 8'h2D + 8'(i), 5'(i), 1'b1, 1'b1, 8'd7);
      end
   endtask

   task automatic wait_q(input int n, input int budget);
      int k = 0;
      while (exp_q.size() > n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("scoreboard_progress_timeout", 32'(exp_q.size() > n), 32'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_lcd_e", 32'(lcd_e), 32'd0);
      chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
      chk("rst_lcd_data", 32'(lcd_data), 32'd0);
      chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);
      chk("rst_index", 32'(index), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_frame_busy", 32'(frame_busy), 32'd0);
   endtask

   // Monitor: a write is taken when lcd_e is seen falling; also times lcd_e low/high widths.
   initial begin
      logic prev_e, prev_fb;
      int   lo, hi, lo_rise;
      exp_t ex;
      prev_e = 1'b0; prev_fb = 1'b0; lo = 1; hi = 0; lo_rise = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_e = 1'b0; prev_fb = 1'b0; lo = 1; hi = 0;
         end else begin
            if (lcd_e && !prev_e) begin
               lo_rise = lo;
               hi = 1;
            end else if (lcd_e) begin
               hi++;
            end else if (prev_e) begin
               chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  ex = exp_q.pop_front();
                  chk("wr_rs", 32'(lcd_rs), 32'(ex.rs));
                  chk("wr_data", 32'(lcd_data), 32'(ex.data));
                  chk("wr_rw", 32'(lcd_rw), 32'd0);
                  chk("wr_index", 32'(index), 32'(ex.idx));
                  chk("wr_frame_busy", 32'(frame_busy), 32'(ex.fb));
                  chk("wr_init_done", 32'(init_done), 32'(ex.idn));
                  chk("wr_gap_before_e", 32'(lo_rise), 32'(ex.lo));
                  chk("wr_e_high_len", 32'(hi), 32'd3);
               end
               lo = 1;
            end else begin
               lo++;
            end
            if (prev_fb && !frame_busy) begin
               chk("frame_end_index_wrap", 32'(index), 32'd0);
               chk("frame_end_init_done", 32'(init_done), 32'd1);
            end
            prev_e  = lcd_e;
            prev_fb = frame_busy;
         end
      end
   end

   initial begin
      int k;
      rst = 1'b0;
      refresh_req = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs();

      // Init, frame 1 straight after init, frame 2 after the full refresh interval (5+50+2).
      push_init();
      push_frame(8'd7);
      push_frame(8'd57);
      // Frame 3 on the timer; frame 4 follows a 1-cycle IDLE forced by refresh_req (5+1+2).
      push_frame(8'd57);
      push_frame(8'd8);
      @(negedge clk);
      #2 rst = 1'b1;

      wait_q(54, 5000);
      refresh_req = 1'b1;
      @(negedge clk);
      refresh_req = 1'b0;
      repeat (7) @(negedge clk);
      refresh_req = 1'b1;
      @(negedge clk);
      refresh_req = 1'b0;

      // Reset in the middle of a write while lcd_e is high.
      wait_q(20, 3000);
      k = 0;
      while (!lcd_e && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("e_high_before_reset", 32'(lcd_e), 32'd1);
      #2 rst = 1'b0;
      exp_q.delete();
      #1 chk_reset_outputs();
      push_init();
      push_frame(8'd7);
      @(negedge clk);
      #2 rst = 1'b1;
      wait_q(0, 3000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
